// File: rtl/spi_slave.sv
// spi_slave: SPI slave endpoint oversampling SCLK/MOSI/SSbar in the clk domain.
// Shifts WORD_LENGTH-bit words MSB first in any of the four SPI modes, with a
// one-word TX holding register and a valid/ready RX output register.
// Optional feature macro: SPI_SLAVE_OVERRUN_DET_EN (sticky rx_overrun flag).
module spi_slave #(
  parameter int                     SPI_MODE    = 0,
  parameter int                     WORD_LENGTH = 8,
  parameter logic [WORD_LENGTH-1:0] DEFAULT_TX  = WORD_LENGTH'(8'hFF)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   SCLK,
  input  logic                   MOSI,
  input  logic                   SSbar,
  output logic                   MISO,
  output logic                   miso_oe,
  input  logic [WORD_LENGTH-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [WORD_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   busy,
  output logic                   rx_overrun
);

  localparam bit CPOL  = ((SPI_MODE >> 1) & 1) == 1;
  localparam bit CPHA  = (SPI_MODE & 1) == 1;
  localparam int CNT_W = (WORD_LENGTH > 2) ? $clog2(WORD_LENGTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_LENGTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                 state;
  logic [2:0]             sclk_s;
  logic [1:0]             mosi_s;
  logic [1:0]             ss_s;
  logic [CNT_W-1:0]       bit_cnt;
  logic [WORD_LENGTH-1:0] tx_sr;
  logic [WORD_LENGTH-2:0] rx_sr;
  logic [WORD_LENGTH-1:0] tx_hold;
  logic                   tx_pending;
  logic                   first_shift;

  logic                   sclk_rise, sclk_fall;
  logic                   lead_edge, trail_edge;
  logic                   sample_edge, shift_edge;
  logic                   ss_active;
  logic [WORD_LENGTH-1:0] load_word;
  logic [WORD_LENGTH-1:0] rx_next;

  // Synchronise the asynchronous SPI pins; the third SCLK stage feeds edge detection.
  // NOTE: async reset sits in the sensitivity list so flops clear without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= {3{CPOL}};
      mosi_s <= '0;
      ss_s   <= 2'b11;
    end else begin
      sclk_s <= {sclk_s[1:0], SCLK};
      mosi_s <= {mosi_s[0], MOSI};
      ss_s   <= {ss_s[0], SSbar};
    end
  end

  assign sclk_rise   = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall   = ~sclk_s[1] & sclk_s[2];
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign ss_active   = ~ss_s[1];
  assign load_word   = tx_pending ? tx_hold : DEFAULT_TX;
  assign rx_next     = {rx_sr, mosi_s[1]};
  assign tx_ready    = ~tx_pending;

`ifdef SPI_SLAVE_OVERRUN_DET_EN
  logic overrun_q;
  assign rx_overrun = overrun_q;
`else
  assign rx_overrun = 1'b0;
`endif

  // Transfer FSM with TX holding register, shifters and RX handshake.
  // NOTE: non-blocking assignments, so a later assignment in this block wins;
  // completion setting rx_valid overrides the consume-clear issued above it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      tx_hold     <= '0;
      tx_pending  <= 1'b0;
      first_shift <= 1'b0;
      MISO        <= 1'b0;
      miso_oe     <= 1'b0;
      busy        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_DET_EN
      overrun_q   <= 1'b0;
`endif
    end else begin
      if (tx_valid && !tx_pending) begin
        tx_hold    <= tx_data;
        tx_pending <= 1'b1;
      end

      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (state != IDLE && !ss_active) begin
        // Deselect aborts the word: partial RX bits and the loaded TX word are dropped.
        state   <= IDLE;
        bit_cnt <= '0;
        MISO    <= 1'b0;
        miso_oe <= 1'b0;
        busy    <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_DET_EN
        overrun_q <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            MISO    <= 1'b0;
            miso_oe <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= '0;
            if (ss_active) begin
              state       <= LOAD;
              tx_sr       <= load_word;
              MISO        <= load_word[WORD_LENGTH-1];
              first_shift <= CPHA;
              miso_oe     <= 1'b1;
              busy        <= 1'b1;
              if (tx_pending) tx_pending <= 1'b0;
            end
          end
          LOAD: state <= SHIFT;
          SHIFT: begin
            if (sample_edge) begin
              if (bit_cnt == LAST_BIT) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                bit_cnt  <= '0;
                state    <= DONE;
`ifdef SPI_SLAVE_OVERRUN_DET_EN
                if (rx_valid && !rx_ready) overrun_q <= 1'b1;
`endif
              end else begin
                rx_sr   <= rx_next[WORD_LENGTH-2:0];
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            if (shift_edge) begin
              if (first_shift) begin
                MISO        <= tx_sr[WORD_LENGTH-1];
                first_shift <= 1'b0;
              end else begin
                MISO  <= tx_sr[WORD_LENGTH-2];
                tx_sr <= tx_sr << 1;
              end
            end
          end
          DONE: begin
            // Next word: MISO keeps the last bit until the next shift edge presents the MSB.
            tx_sr       <= load_word;
            first_shift <= 1'b1;
            state       <= SHIFT;
            if (tx_pending) tx_pending <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives one spi_slave per SPI mode from a behavioural SPI master.
// Received words are checked by a scoreboard monitor; MISO words and status
// flags are checked directly against hand-computed values.
module tb_spi_slave;

  localparam int H = 8;  // SCLK half period in clk cycles
`ifdef SPI_SLAVE_OVERRUN_DET_EN
  localparam bit EXP_OVR = 1'b1;
`else
  localparam bit EXP_OVR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sclk[4], mosi[4], ssbar[4], miso[4], miso_oe[4];
  logic       tx_valid[4], tx_ready[4], rx_valid[4], rx_ready[4], busy[4], rx_overrun[4];
  logic [7:0] tx_data[4], rx_data[4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(.SPI_MODE(g), .WORD_LENGTH(8), .DEFAULT_TX(8'hFF)) u_dut (
      .clk(clk), .rst_n(rst_n), .SCLK(sclk[g]), .MOSI(mosi[g]), .SSbar(ssbar[g]),
      .MISO(miso[g]), .miso_oe(miso_oe[g]), .tx_data(tx_data[g]), .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]), .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
      .rx_ready(rx_ready[g]), .busy(busy[g]), .rx_overrun(rx_overrun[g])
    );
  end

  typedef struct {
    int         dut;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         rx_rises[4];
  int         rise_cycle[4];
  logic       rx_valid_d[4];
  bit         tx_ready_low[4];
  int         last_lead;
  int         base;
  logic [7:0] mi, mi1, mi2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expected word on every rx handshake.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (rx_valid[g] === 1'b1 && rx_valid_d[g] === 1'b0) begin
        rx_rises[g]++;
        rise_cycle[g] = cyc;
      end
      rx_valid_d[g] = rx_valid[g];
      if (tx_ready[g] === 1'b0) tx_ready_low[g] = 1'b1;
      if (rx_valid[g] === 1'b1 && rx_ready[g] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected rx word: dut %0d got %0h, expected none", g, rx_data[g]);
        end else begin
          mon_e = exp_q.pop_front();
          check("rx dut index", g, mon_e.dut);
          check("rx_data", rx_data[g], mon_e.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic write_tx(input int g, input logic [7:0] d);
    int t = 0;
    while (tx_ready[g] !== 1'b1 && t < 100) begin
      tick(1);
      t++;
    end
    if (t == 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL tx_ready timeout: dut %0d got 0, expected 1", g);
    end
    tx_data[g]  = d;
    tx_valid[g] = 1'b1;
    tick(1);
    tx_valid[g] = 1'b0;
  endtask

  task automatic ss_assert(input int g);
    ssbar[g] = 1'b0;
    tick(4);
  endtask

  task automatic ss_release(input int g);
    tick(H);
    ssbar[g] = 1'b1;
    tick(4);
  endtask

  // Behavioural master: shifts nbits of mo MSB first, returns bits read from MISO.
  task automatic xfer(input int g, input logic [7:0] mo, input int nbits, output logic [7:0] mr);
    logic cpol, cpha;
    cpol = ((g >> 1) & 1) == 1;
    cpha = (g & 1) == 1;
    mr = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi[g] = mo[i];
      if (!cpha) begin
        tick(H);
        mr[i]     = miso[g];
        sclk[g]   = ~cpol;
        last_lead = cyc;
        tick(H);
        sclk[g]   = cpol;
      end else begin
        sclk[g]   = ~cpol;
        last_lead = cyc;
        tick(H);
        mr[i]     = miso[g];
        sclk[g]   = cpol;
        tick(H);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int g = 0; g < 4; g++) begin
      sclk[g]     = ((g >> 1) & 1) == 1;
      mosi[g]     = 1'b0;
      ssbar[g]    = 1'b1;
      tx_valid[g] = 1'b0;
      tx_data[g]  = '0;
      rx_ready[g] = 1'b1;
    end
    tick(3);
    for (int g = 0; g < 4; g++) begin
      check("reset flags {miso,oe,tx_rdy,rx_vld,busy,ovr}",
            {miso[g], miso_oe[g], tx_ready[g], rx_valid[g], busy[g], rx_overrun[g]}, 6'b001000);
      check("reset rx_data", rx_data[g], 8'h00);
    end
    rst_n = 1'b1;
    tick(3);

    // Mode 0: preloaded A5, master sends 3C.
    write_tx(0, 8'hA5);
    check("m0 tx_ready drops after write", tx_ready[0], 1'b0);
    base = rx_rises[0];
    exp_q.push_back('{0, 8'h3C});
    ss_assert(0);
    check("m0 busy while selected", busy[0], 1'b1);
    check("m0 miso_oe while selected", miso_oe[0], 1'b1);
    check("m0 tx_ready after load", tx_ready[0], 1'b1);
    xfer(0, 8'h3C, 8, mi);
    check("m0 miso word", mi, 8'hA5);
    check("m0 rx_valid within 3 clk", (rise_cycle[0] - last_lead >= 1) && (rise_cycle[0] - last_lead <= 3), 1);
    check("m0 rx_valid rises once", rx_rises[0] - base, 1);
    ss_release(0);
    check("m0 busy after deselect", busy[0], 1'b0);

    // Mode 3: nothing pending, master sends 81.
    tx_ready_low[3] = 1'b0;
    base = rx_rises[3];
    exp_q.push_back('{3, 8'h81});
    ss_assert(3);
    xfer(3, 8'h81, 8, mi);
    ss_release(3);
    check("m3 miso default word", mi, 8'hFF);
    check("m3 tx_ready never low", tx_ready_low[3], 1'b0);
    check("m3 rx_valid rises once", rx_rises[3] - base, 1);

    // Modes 1 and 2: two back-to-back words under one select.
    for (int g = 1; g <= 2; g++) begin
      write_tx(g, 8'h12);
      base = rx_rises[g];
      exp_q.push_back('{g, 8'hC3});
      exp_q.push_back('{g, 8'h7E});
      ss_assert(g);
      fork
        xfer(g, 8'hC3, 8, mi1);
        begin
          tick(3 * H);
          write_tx(g, 8'h34);
        end
      join
      xfer(g, 8'h7E, 8, mi2);
      ss_release(g);
      check("b2b first miso word", mi1, 8'h12);
      check("b2b second miso word", mi2, 8'h34);
      check("b2b two rx_valid events", rx_rises[g] - base, 2);
    end

    // Mode 0 abort after 4 bits: loaded word lost, held word kept.
    write_tx(0, 8'h99);
    base = rx_rises[0];
    ss_assert(0);
    fork
      xfer(0, 8'hF0, 4, mi);
      begin
        tick(H);
        write_tx(0, 8'h66);
      end
    join
    tick(H);
    check("abort busy before deselect", busy[0], 1'b1);
    ssbar[0] = 1'b1;
    tick(3);
    check("abort busy within 3 clk", busy[0], 1'b0);
    check("abort miso_oe within 3 clk", miso_oe[0], 1'b0);
    check("abort miso idle", miso[0], 1'b0);
    tick(20);
    check("abort no rx_valid", rx_rises[0] - base, 0);
    check("abort held word kept", tx_ready[0], 1'b0);
    exp_q.push_back('{0, 8'h5A});
    ss_assert(0);
    xfer(0, 8'h5A, 8, mi);
    ss_release(0);
    check("after abort miso word", mi, 8'h66);
    check("after abort one rx_valid", rx_rises[0] - base, 1);

    // Mode 0 with rx_ready low across two words.
    rx_ready[0] = 1'b0;
    base = rx_rises[0];
    ss_assert(0);
    xfer(0, 8'h11, 8, mi);
    xfer(0, 8'h22, 8, mi);
    tick(4);
    check("overrun flag", rx_overrun[0], EXP_OVR);
    check("overrun rx_valid held", rx_valid[0], 1'b1);
    check("overrun single rx_valid rise", rx_rises[0] - base, 1);
    exp_q.push_back('{0, 8'h22});
    rx_ready[0] = 1'b1;
    tick(2);
    check("rx_valid cleared after consume", rx_valid[0], 1'b0);
    ss_release(0);
    check("overrun cleared on idle", rx_overrun[0], 1'b0);

    // Mode 2: reset mid-word, then a normal transfer.
    ss_assert(2);
    write_tx(2, 8'h77);
    xfer(2, 8'hF0, 3, mi);
    check("pre-reset tx_ready", tx_ready[2], 1'b0);
    check("pre-reset busy", busy[2], 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid-reset flags {miso,oe,tx_rdy,rx_vld,busy,ovr}",
          {miso[2], miso_oe[2], tx_ready[2], rx_valid[2], busy[2], rx_overrun[2]}, 6'b001000);
    check("mid-reset rx_data", rx_data[2], 8'h00);
    tick(2);
    ssbar[2] = 1'b1;
    sclk[2]  = 1'b1;
    rst_n    = 1'b1;
    tick(3);
    write_tx(2, 8'h3C);
    exp_q.push_back('{2, 8'hE7});
    ss_assert(2);
    xfer(2, 8'hE7, 8, mi);
    ss_release(2);
    check("post-reset miso word", mi, 8'h3C);

    tick(5);
    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave endpoint that consumes SCLK/MOSI/SSbar from the SPI master and returns MISO.
- Oversamples all SPI pins in the local clk domain and shifts WORD_LENGTH-bit words MSB first.
- Presents received words, and accepts words to transmit, over valid/ready handshakes to local logic.
- Serves as the bench-side and on-chip counterpart for every SPI mode the master supports.

Parameters:
SPI_MODE, 0, {CPOL,CPHA} encoding: 0=00, 1=01, 2=10, 3=11
WORD_LENGTH, 8, bits per SPI word
DEFAULT_TX, 8'hFF, word shifted out when no TX word is pending (width WORD_LENGTH)

Ports:
clk  in  1  system clock, must be at least 8x the SCLK frequency
rst_n  in  1  asynchronous active-low reset
SCLK  in  1  SPI clock from master (asynchronous)
MOSI  in  1  serial data from master (asynchronous)
SSbar  in  1  active-low slave select (asynchronous)
MISO  out  1  serial data to master
miso_oe  out  1  MISO output enable, high while selected
tx_data  in  WORD_LENGTH  word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX holding register empty
rx_data  out  WORD_LENGTH  last received word
rx_valid  out  1  rx_data holds an unread word
rx_ready  in  1  local logic consumes rx_data
busy  out  1  SSbar asserted, transfer in progress
rx_overrun  out  1  sticky overrun flag (see Optional Feature)

Behaviour:
- Reset is asynchronous on rst_n, active-low, clock is clk. Reset values:
  - MISO=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, rx_overrun=0.
  - Bit counter=0, state=IDLE.
- Synchronisation: SCLK, MOSI and SSbar each pass through a 2-FF synchroniser. A third SCLK stage provides edge detection.
- Edge decode:
  - CPOL=0: leading edge = rising. CPOL=1: leading edge = falling.
  - CPHA=0: sample on leading, shift on trailing. CPHA=1: shift on leading, sample on trailing.
- TX holding register:
  - tx_valid & tx_ready captures tx_data; tx_ready drops the next cycle.
  - tx_ready returns high the cycle after the word is moved into the shift register.
- State machine:
  - IDLE: SSbar high, miso_oe=0, MISO=0. A synced SSbar fall moves to LOAD.
  - LOAD (1 clk): shift register takes the held TX word if pending, else DEFAULT_TX. busy=1, miso_oe=1. For CPHA=0, MISO = MSB from this cycle. Next state is SHIFT.
  - SHIFT:
    - Each sample edge shifts synced MOSI into the RX shifter LSB and increments the bit counter.
    - Each shift edge advances MISO to the next bit. For CPHA=1, the first leading edge drives the MSB, and the first shift edge of a word does not advance.
    - The sample edge that makes the counter reach WORD_LENGTH transfers the RX shifter to rx_data, sets rx_valid on the next clk, clears the counter and moves to DONE.
  - DONE (1 clk):
    - If SSbar is still low, reload the TX shift register (pending word or DEFAULT_TX) and return to SHIFT.
    - For CPHA=0, the new MSB appears on MISO at the trailing edge following the last sample.
    - If SSbar is high, go to IDLE.
- SSbar rises at any point:
  - Go to IDLE within 3 clk. miso_oe=0, busy=0.
  - Partial RX bits are discarded and rx_valid is not raised.
  - A TX word already loaded into the shift register is lost. A word still in the holding register is kept.
- rx_valid stays high until rx_valid & rx_ready, then clears the next clk.
- Completion and rx_ready in the same cycle: the new word wins and rx_valid stays 1.
- SCLK edges while SSbar is high are ignored.

Optional Feature:
- Macro: SPI_SLAVE_OVERRUN_DET_EN
- Defined: a word completing while rx_valid=1 and rx_ready=0 still overwrites rx_data, and sets rx_overrun. rx_overrun is sticky and clears only on reset or on an IDLE entry.
- Undefined: rx_overrun is tied to 0. Overwrite behaviour is unchanged.

Test Plan:
- Mode 0, tx word 8'hA5 preloaded, master sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; rx_valid rises once within 3 clk of the 8th rising SCLK.
- Mode 3, no TX word pending, master sends 8'h81 -> MISO returns 8'hFF; rx_data=8'h81; tx_ready=1 throughout.
- Modes 1 and 2, two back-to-back words (TX 8'h12, then 8'h34 written during word 1) with SSbar held low -> master reads 12h then 34h; two rx_valid events.
- SSbar deasserted after 4 SCLK cycles -> no rx_valid; busy=0 and miso_oe=0 within 3 clk; the next full transfer of 8'h5A is received correctly.
- rx_ready held 0 across two words (8'h11, 8'h22) -> rx_data=8'h22; rx_overrun=1 with the macro, 0 without it.
- rst_n asserted mid-word -> all outputs return to reset values immediately; the following transfer works normally.
